// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the instruction-fetch stage.
//   PC_W             word-address width (byte address [31:2])
//   INSTR_W          instruction word width
//   RESET_PC_DEFAULT default boot word address (byte 0x0000_3000)
//   state_t          fetch control states
//   pc_inc()         next sequential word address, wraps 3FFF_FFFF -> 0
package pc_fetch_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0000_0C00;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 30'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/response bus.
//   imem_req    request valid (fetch -> memory)
//   imem_addr   word address [31:2] of the request
//   imem_gnt    request accepted this cycle
//   imem_rvalid response valid, in order, at least one cycle after grant
//   imem_rdata  instruction word
// Modports: master = fetch stage, slave = instruction memory.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/pc_fetch_fifo.sv
// fetch_fifo: synchronous ring-buffer FIFO used both as the fetch buffer
// ({pc, instr} entries) and as the queue of PCs awaiting a response.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       drop all entries (dominates push/pop)
//   push, wdata write an entry
//   pop         retire the head entry
//   rdata       head entry, read from registered storage
//   count       number of entries held
//   empty, full occupancy flags
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full buffer is accepted only when the head leaves the same edge.
    assign do_push = push && (!full || do_pop);

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush))
        else $error("fetch_fifo overflow");

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and instruction-fetch stage.
// Holds the word-addressed PC, issues in-order requests on the imem bus,
// pairs every returned word with the PC it was fetched from and buffers
// the pairs for decode. A redirect loads npc_in, flushes the buffer and
// discards every response still in flight for the old path.
//   clk, rst_n        clock, asynchronous active-low reset
//   imem              pc_fetch_if.master instruction-memory bus
//   if_valid/ready    decode handshake (valid & ready = pop)
//   if_instr, if_pc   buffered instruction and its word address
//   redirect, npc_in  taken branch/jump and its target word address
// Optional: define PC_FETCH_PERF_EN to add perf_fetch_cnt (accepted
// instructions) and perf_flush_cnt (discarded responses + flushed entries).
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pc_fetch_if.master         imem,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    npc_in
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             grant, resp, pop;
    logic             fifo_push, pcq_push, pcq_pop;
    logic [CNT_W-1:0] fifo_count, pcq_count;
    logic             fifo_empty, fifo_full, pcq_empty, pcq_full;
    logic [PC_W-1:0]  pcq_head;

    // Request side depends on registered state only, never on imem_gnt.
    assign imem.imem_req  = (state_q == S_RUN) &&
                            ((int'(outst_q) + int'(fifo_count)) < DEPTH);
    assign imem.imem_addr = pc_q;

    assign grant    = imem.imem_req && imem.imem_gnt;
    assign resp     = imem.imem_rvalid;
    assign if_valid = !fifo_empty && (state_q != S_BOOT);
    assign pop      = if_valid && if_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        outst_d   = outst_q + CNT_W'(grant) - CNT_W'(resp);
        fifo_push = 1'b0;
        pcq_push  = 1'b0;
        pcq_pop   = 1'b0;

        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (grant) begin
                    pc_d     = pc_inc(pc_q);
                    pcq_push = 1'b1;
                end
                if (resp) begin
                    fifo_push = 1'b1;
                    pcq_pop   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (resp) begin
                    drop_d = drop_q - CNT_W'(1);
                end
                if (drop_d == '0) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase

        // Everything in flight after this edge, including a grant or a
        // response landing this very cycle, belongs to the abandoned path.
        if (redirect) begin
            pc_d      = npc_in;
            fifo_push = 1'b0;
            pcq_push  = 1'b0;
            pcq_pop   = 1'b0;
            drop_d    = outst_d;
            state_d   = (outst_d != '0) ? S_DRAIN : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // ---- stage boundary: PCs awaiting their response ----
    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PC_W)
    ) u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (pcq_push),
        .pop   (pcq_pop),
        .wdata (pc_q),
        .rdata (pcq_head),
        .count (pcq_count),
        .empty (pcq_empty),
        .full  (pcq_full)
    );

    // ---- stage boundary: {pc, instr} pairs waiting for decode ----
    fetch_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PC_W + INSTR_W)
    ) u_fetch_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect),
        .push  (fifo_push),
        .pop   (pop),
        .wdata ({pcq_head, imem.imem_rdata}),
        .rdata ({if_pc, if_instr}),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    pcq_nonempty_on_resp: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_pop |-> !pcq_empty);
    pcq_room_on_grant: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_push |-> (!pcq_full || pcq_pop));
    buf_room_on_resp: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_push |-> (!fifo_full || pop));
    pcq_tracks_outst: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_RUN) |-> (pcq_count == outst_q));

`ifdef PC_FETCH_PERF_EN
    logic discard;

    // A response is thrown away while draining or when it meets a redirect;
    // a popped head is delivered, so only the remaining entries are flushed.
    assign discard = resp && ((state_q == S_DRAIN) || redirect);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'(pop);
            perf_flush_cnt <= perf_flush_cnt + 32'(discard) +
                              (redirect ? (32'(fifo_count) - 32'(pop)) : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    localparam logic [PC_W-1:0] RESET_PC = 30'h0000_0C00;
    localparam int              DEPTH    = 2;

    logic               clk;
    logic               rst_n;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               redirect;
    logic [PC_W-1:0]    npc_in;
`ifdef PC_FETCH_PERF_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    pc_fetch_if ifc ();

    pc_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (ifc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect       (redirect),
        .npc_in         (npc_in)
`ifdef PC_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- memory model and reference state ----
    typedef struct {
        logic [PC_W-1:0] addr;
        int              due;
    } req_t;

    req_t            mq[$];
    int              cyc, last_due;
    int              held;        // current-path words granted but not yet popped
    int              wrong;       // abandoned-path responses still to arrive
    logic [PC_W-1:0] exp_pc, exp_addr;
    int              exp_fetch, exp_flush;
    bit              in_rst;
    bit              hold_prev;
    logic [PC_W-1:0] hold_pc;
    logic [31:0]     hold_instr;
    int              p_gnt, p_lat, p_ready, p_redir;
    bit              force_redir;
    logic [PC_W-1:0] force_npc;
    int              n_pop, n_grant;
    int              n_tests, n_fail;

    function automatic logic [31:0] word(input logic [PC_W-1:0] a);
        return {a, 2'b00} ^ 32'hC3A5_5A3C ^ {a[14:0], a[29:13]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cycle(input bit rst_req);
        logic            s_req, s_valid;
        logic [PC_W-1:0] s_addr, s_pc, npc;
        logic [31:0]     s_instr;
        int              buffered, lat, due;
        bit              grant, resp, pop;

        @(negedge clk);
        cyc++;
        s_req    = ifc.imem_req;
        s_addr   = ifc.imem_addr;
        s_valid  = if_valid;
        s_pc     = if_pc;
        s_instr  = if_instr;
        buffered = held - (mq.size() - wrong);

        if (in_rst) begin
            chk("rst_imem_req", s_req, 0);
            chk("rst_imem_addr", s_addr, RESET_PC);
            chk("rst_if_valid", s_valid, 0);
            chk("rst_if_instr", s_instr, 0);
            chk("rst_if_pc", s_pc, 0);
        end else begin
            chk("imem_req", s_req, (wrong == 0) && (held < DEPTH));
            chk("if_valid", s_valid, buffered > 0);
            if (hold_prev) begin
                chk("hold_if_pc", s_pc, hold_pc);
                chk("hold_if_instr", s_instr, hold_instr);
            end
        end
        hold_prev = 1'b0;

        if (rst_req || in_rst) begin
            rst_n       = rst_req ? 1'b0 : 1'b1;
            ifc.imem_gnt    = 1'b0;
            ifc.imem_rvalid = 1'b0;
            ifc.imem_rdata  = '0;
            if_ready    = 1'b0;
            redirect    = 1'b0;
            npc_in      = '0;
            mq.delete();
            held      = 0;
            wrong     = 0;
            last_due  = 0;
            exp_pc    = RESET_PC;
            exp_addr  = RESET_PC;
            exp_fetch = 0;
            exp_flush = 0;
            in_rst    = rst_req;
            return;
        end

        if_ready     = ($urandom_range(99) < p_ready);
        ifc.imem_gnt = ($urandom_range(99) < p_gnt);
        if (force_redir) begin
            redirect    = 1'b1;
            npc         = force_npc;
            force_redir = 1'b0;
        end else begin
            redirect = ($urandom_range(999) < p_redir);
            npc      = 30'($urandom());
        end
        npc_in = redirect ? npc : 30'($urandom());
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            ifc.imem_rvalid = 1'b1;
            ifc.imem_rdata  = word(mq[0].addr);
        end else begin
            ifc.imem_rvalid = 1'b0;
            ifc.imem_rdata  = $urandom();
        end

        grant = s_req && ifc.imem_gnt;
        resp  = ifc.imem_rvalid;
        pop   = s_valid && if_ready;

        if (grant) begin
            chk("imem_addr", s_addr, exp_addr);
            exp_addr = exp_addr + 30'd1;
            lat      = $urandom_range(p_lat, 1);
            due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = due;
            mq.push_back('{addr: s_addr, due: due});
            held++;
            n_grant++;
        end
        if (pop) begin
            chk("if_pc", s_pc, exp_pc);
            chk("if_instr", s_instr, word(exp_pc));
            exp_pc = exp_pc + 30'd1;
            held--;
            exp_fetch++;
            n_pop++;
        end
        if (resp) begin
            void'(mq.pop_front());
            if (wrong > 0) begin
                wrong--;
                exp_flush++;
            end else if (redirect) begin
                exp_flush++;
            end
        end
        if (redirect) begin
            exp_flush += buffered - (pop ? 1 : 0);
            held     = 0;
            wrong    = mq.size();
            exp_pc   = npc;
            exp_addr = npc;
        end else if (s_valid && !if_ready) begin
            hold_prev  = 1'b1;
            hold_pc    = s_pc;
            hold_instr = s_instr;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b1);
        cycle(1'b0);
    endtask

    task automatic run(input int n, input int pg, input int pl, input int pr, input int pd);
        int pops0;
        p_gnt   = pg;
        p_lat   = pl;
        p_ready = pr;
        p_redir = pd;
        pops0   = n_pop;
        repeat (n) cycle(1'b0);
        if (pr > 0) chk("progress", n_pop > pops0, 1);
    endtask

    initial begin
        int g0;
        rst_n           = 1'b0;
        ifc.imem_gnt    = 1'b0;
        ifc.imem_rvalid = 1'b0;
        ifc.imem_rdata  = '0;
        if_ready        = 1'b0;
        redirect        = 1'b0;
        npc_in          = '0;
        in_rst          = 1'b1;
        hold_prev       = 1'b0;
        force_redir     = 1'b0;
        force_npc       = '0;
        cyc = 0; last_due = 0; held = 0; wrong = 0;
        exp_pc = RESET_PC; exp_addr = RESET_PC;
        exp_fetch = 0; exp_flush = 0;
        n_pop = 0; n_grant = 0; n_tests = 0; n_fail = 0;
        p_gnt = 100; p_lat = 1; p_ready = 100; p_redir = 0;

        do_reset(3);

        // Decode stalled: only DEPTH requests may be granted.
        g0 = n_grant;
        run(8, 100, 1, 0, 0);
        chk("stall_grants", n_grant - g0, DEPTH);

        // Streaming with a single-cycle memory.
        run(30, 100, 1, 100, 0);

        // Directed redirect into a busy pipeline.
        force_redir = 1'b1;
        force_npc   = 30'h0000_1000;
        run(30, 100, 1, 100, 0);

        // Variable latency, toggling grant/ready, random redirects.
        run(1500, 60, 4, 70, 30);

        // Wrap across the top of the address space.
        force_redir = 1'b1;
        force_npc   = 30'h3FFF_FFFD;
        run(30, 100, 2, 100, 0);

        // Reset in the middle of traffic, then resume.
        run(40, 80, 4, 80, 20);
        do_reset(2);
        run(600, 70, 3, 60, 40);

        // Long stall followed by release.
        run(10, 100, 2, 0, 0);
        run(40, 100, 2, 100, 0);

`ifdef PC_FETCH_PERF_EN
        @(negedge clk);
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(exp_fetch));
        chk("perf_flush_cnt", perf_flush_cnt, 32'(exp_flush));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
